// File: rtl/simd_mem_pkg.sv
// Shared types for the per-core SIMD memory request sequencer.
// Optional SIMD_MEM_WRACK_EN makes stores return a completion pulse.
package simd_mem_pkg;

    localparam int LANE_W = 8;
    localparam int NCORES = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    typedef struct packed {
        logic              we;
        logic [LANE_W-1:0] addr;
        logic [LANE_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/simd_req_fifo.sv
// Synchronous request FIFO; pointers carry an extra wrap bit
// so full and empty are distinguished without a counter.
module simd_req_fifo
    import simd_mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  req_t data_i,
    input  logic pop_i,
    output req_t data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    req_t        mem_q [DEPTH];
    logic        do_push, do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign wr_d    = wr_q + {{AW{1'b0}}, do_push};
    assign rd_d    = rd_q + {{AW{1'b0}}, do_pop};
    assign data_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/simd_mem_port.sv
// Per-core byte load/store sequencer in front of the shared-RAM arbiter.
// Define SIMD_MEM_WRACK_EN to pulse rsp_valid on store completion too.
module simd_mem_port
    import simd_mem_pkg::*;
#(
    parameter int CORE_ID    = 0,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LAT     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [LANE_W-1:0] req_addr,
    input  logic [LANE_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [LANE_W-1:0] rsp_data,
    output logic              arb_rden,
    output logic              arb_wren,
    output logic [LANE_W-1:0] arb_addr,
    output logic [LANE_W-1:0] arb_din,
    input  logic              arb_acq,
    input  logic [LANE_W-1:0] arb_q,
    output logic              busy
);

    localparam int            CW       = $clog2(RD_LAT) + 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(RD_LAT - 1);

    state_t            state_q, state_d;
    req_t              cmd_q, cmd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [LANE_W-1:0] rsp_q, rsp_d;

    req_t fifo_head;
    logic fifo_full, fifo_empty, fifo_pop;
    logic in_req;

    simd_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (req_valid && req_ready),
        .data_i  ('{we: req_we, addr: req_addr, wdata: req_wdata}),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        cnt_d    = cnt_q;
        rsp_d    = rsp_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cmd_d    = fifo_head;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                if (arb_acq) begin
                    if (cmd_q.we) begin
`ifdef SIMD_MEM_WRACK_EN
                        state_d = ST_RESP;
`else
                        state_d = ST_IDLE;
`endif
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    rsp_d   = arb_q;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            cnt_q   <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            cnt_q   <= cnt_d;
            rsp_q   <= rsp_d;
        end
    end

    // Outputs are forced low while rst is asserted, before the reset edge lands
    assign in_req    = (state_q == ST_REQ) && !rst;
    assign arb_rden  = in_req && !cmd_q.we;
    assign arb_wren  = in_req && cmd_q.we;
    assign arb_addr  = in_req ? cmd_q.addr : '0;
    assign arb_din   = in_req ? cmd_q.wdata : '0;
    assign rsp_valid = (state_q == ST_RESP) && !rst;
    assign rsp_data  = rsp_q;
    assign req_ready = !fifo_full && !rst;
    assign busy      = !rst && ((state_q != ST_IDLE) || !fifo_empty);

endmodule

// File: tb/tb_simd_mem_port.sv
// Bench for simd_mem_port: RAM/arbiter model plus in-order response scoreboard.
module tb_simd_mem_port;

    localparam int RD_LAT     = 2;
    localparam int FIFO_DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, req_we;
    logic [7:0] req_addr, req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       arb_rden, arb_wren, arb_acq;
    logic [7:0] arb_addr, arb_din, arb_q;
    logic       busy;

    always #5 clk = ~clk;

    simd_mem_port #(
        .CORE_ID    (0),
        .FIFO_DEPTH (FIFO_DEPTH),
        .RD_LAT     (RD_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .arb_rden  (arb_rden),
        .arb_wren  (arb_wren),
        .arb_addr  (arb_addr),
        .arb_din   (arb_din),
        .arb_acq   (arb_acq),
        .arb_q     (arb_q),
        .busy      (busy)
    );

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } txn_t;

    int         nerr = 0;
    int         nchk = 0;
    logic [7:0] ram     [256];
    logic [7:0] ref_mem [256];
    txn_t       issue_q [$];
    logic [7:0] exp_q   [$];
    logic [7:0] last_rsp;
    int         gdelay    = 1;
    bit         spur      = 1'b0;
    int         rsp_cnt   = 0;
    int         grant_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: every request completes in push order against a flat byte RAM
    task automatic model_push(input logic we, input logic [7:0] a,
                              input logic [7:0] d);
        issue_q.push_back('{we: we, addr: a, wdata: d});
        if (we) begin
            ref_mem[a] = d;
`ifdef SIMD_MEM_WRACK_EN
            exp_q.push_back(last_rsp);
`endif
        end else begin
            last_rsp = ref_mem[a];
            exp_q.push_back(last_rsp);
        end
    endtask

    task automatic push(input logic we, input logic [7:0] a,
                        input logic [7:0] d, output int waited);
        waited    = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        #1;
        while (!req_ready) begin
            @(negedge clk);
            #1;
            waited++;
            if (waited > 300) begin
                chk("push_timeout", 0, 1);
                req_valid = 1'b0;
                return;
            end
        end
        model_push(we, a, d);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        @(negedge clk);
        #3;
        while (exp_q.size() != 0 || issue_q.size() != 0 || busy) begin
            @(negedge clk);
            #3;
            n++;
            if (n > 500) begin
                chk(tag, 0, 1);
                break;
            end
        end
    endtask

    // Arbiter + RAM model and response monitor, acting 2 units after negedge
    initial begin
        int         wcnt    = 0;
        int         rd_left = -1;
        logic [7:0] rd_addr = '0;
        bit         granted = 1'b0;
        logic [16:0] held   = '0;
        txn_t       t;
        arb_acq = 1'b0;
        arb_q   = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                arb_acq = 1'b0;
                wcnt    = 0;
                rd_left = -1;
                granted = 1'b0;
                continue;
            end
            if (rsp_valid) begin
                rsp_cnt++;
                if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
                else chk("rsp_data", rsp_data, exp_q.pop_front());
            end
            if (granted) chk("drop_after_grant", {arb_rden, arb_wren}, 0);
            granted = 1'b0;
            if (rd_left > 0) begin
                rd_left--;
                if (rd_left == 0) begin
                    arb_q   = ram[rd_addr];
                    rd_left = -1;
                end else begin
                    arb_q = 8'($urandom);
                end
            end else begin
                arb_q = 8'($urandom);
            end
            arb_acq = 1'b0;
            if (arb_rden || arb_wren) begin
                if (wcnt == 0) held = {arb_wren, arb_addr, arb_din};
                else chk("req_stable", {arb_wren, arb_addr, arb_din}, held);
                if (wcnt >= gdelay) begin
                    arb_acq = 1'b1;
                    granted = 1'b1;
                    grant_cnt++;
                    wcnt = 0;
                    if (issue_q.size() == 0) begin
                        chk("grant_unexpected", 1, 0);
                    end else begin
                        t = issue_q.pop_front();
                        chk("grant_order", {arb_rden, arb_wren, arb_addr},
                            {!t.we, t.we, t.addr});
                        if (t.we) begin
                            chk("grant_din", arb_din, t.wdata);
                            ram[t.addr] = t.wdata;
                        end else begin
                            rd_addr = t.addr;
                            rd_left = RD_LAT;
                        end
                    end
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
                if (spur) arb_acq = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        int w;
        int c0;
        int nld;
        int g0;
        logic we;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        last_rsp  = '0;
        for (int i = 0; i < 256; i++) begin
            ram[i]     = 8'($urandom);
            ref_mem[i] = ram[i];
        end
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_outs", {rsp_valid, arb_rden, arb_wren, busy}, 0);
        chk("rst_data", {rsp_data, arb_addr, arb_din}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("ready_after_rst", req_ready, 1);

        // Single load with a 1-cycle grant delay
        ram[8'h2A]     = 8'h5C;
        ref_mem[8'h2A] = 8'h5C;
        gdelay = 1;
        c0 = rsp_cnt;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'h2A;
        req_wdata = 8'h00;
        #1;
        chk("load_accept", req_ready, 1);
        model_push(1'b0, 8'h2A, 8'h00);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("rden_n1", arb_rden, 0);
        @(negedge clk);
        #1;
        chk("rden_n2", {arb_rden, arb_addr}, {1'b1, 8'h2A});
        wait_done("load_timeout");
        chk("load_rsp_cnt", rsp_cnt - c0, 1);
        chk("load_rsp_data", rsp_data, 8'h5C);

        // Single store held for several cycles
        gdelay = 3;
        c0 = rsp_cnt;
        push(1'b1, 8'h10, 8'hA5, w);
        w = 0;
        while (!arb_wren && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        chk("store_req", {arb_wren, arb_rden, arb_addr, arb_din},
            {1'b1, 1'b0, 8'h10, 8'hA5});
        wait_done("store_timeout");
`ifdef SIMD_MEM_WRACK_EN
        chk("store_rsp_cnt", rsp_cnt - c0, 1);
`else
        chk("store_rsp_cnt", rsp_cnt - c0, 0);
`endif

        // Burst against a withheld grant: the fifth fits since one is popped
        gdelay = 20;
        c0  = rsp_cnt;
        nld = 0;
        for (int i = 0; i < 5; i++) begin
            we = 1'($urandom_range(0, 1));
            nld += (we == 1'b0) ? 1 : 0;
            push(we, 8'($urandom_range(0, 7)), 8'($urandom), w);
            chk("burst_no_stall", w, 0);
        end
        #1;
        chk("burst_full", req_ready, 0);
        push(1'b0, 8'($urandom_range(0, 7)), 8'h00, w);
        nld++;
        chk("burst_sixth_waited", (w > 0) ? 1 : 0, 1);
        wait_done("burst_timeout");
`ifdef SIMD_MEM_WRACK_EN
        chk("burst_rsp_cnt", rsp_cnt - c0, 6);
`else
        chk("burst_rsp_cnt", rsp_cnt - c0, nld);
`endif

        // Grant latency sweep with spurious acq outside REQ
        spur = 1'b1;
        for (int gd = 0; gd < 8; gd++) begin
            gdelay = gd;
            push(1'b0, 8'($urandom_range(0, 7)), 8'h00, w);
            push(1'b1, 8'($urandom_range(0, 7)), 8'($urandom), w);
            wait_done("sweep_timeout");
        end
        spur = 1'b0;

        // Back-to-back loads: busy must stay high until both have returned
        gdelay = 1;
        ram[8'h01] = 8'h11;
        ref_mem[8'h01] = 8'h11;
        ram[8'h02] = 8'h22;
        ref_mem[8'h02] = 8'h22;
        c0 = rsp_cnt;
        push(1'b0, 8'h01, 8'h00, w);
        push(1'b0, 8'h02, 8'h00, w);
        #3;
        chk("b2b_busy", busy, 1);
        w = 0;
        while (busy && w < 100) begin
            @(negedge clk);
            #3;
            w++;
        end
        chk("b2b_rsp_cnt_at_idle", rsp_cnt - c0, 2);
        chk("b2b_last_data", rsp_data, 8'h22);

        // Reset while a load waits for RAM data
        gdelay = 1;
        g0 = grant_cnt;
        push(1'b0, 8'h05, 8'h00, w);
        w = 0;
        while (grant_cnt == g0 && w < 50) begin
            @(negedge clk);
            #3;
            w++;
        end
        chk("midload_granted", (grant_cnt != g0) ? 1 : 0, 1);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        issue_q.delete();
        c0 = rsp_cnt;
        @(negedge clk);
        #1;
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_outs", {rsp_valid, arb_rden, arb_wren, busy}, 0);
        chk("mid_rst_data", {rsp_data, arb_addr, arb_din}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = ram[i];
        last_rsp = '0;
        @(negedge clk);
        #1;
        chk("mid_ready_after", req_ready, 1);
        repeat (10) @(negedge clk);
        chk("mid_no_rsp", rsp_cnt - c0, 0);

        // Randomised mix of loads and stores over a small address window
        for (int i = 0; i < 40; i++) begin
            spur   = 1'($urandom_range(0, 1));
            gdelay = $urandom_range(0, 4);
            push(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)),
                 8'($urandom), w);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_done("random_timeout");
        chk("random_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
